// File: rtl/alarm_pkg.sv
// Shared alarm-system definitions: keypad codes, keypad FSM state encoding,
// security FSM state constants and small helpers.
package alarm_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  // Keypad front-end states (3-bit encoding, also exported on dbg_state).
  typedef enum logic [2:0] {
    KP_IDLE       = 3'd0,
    KP_ENTRY      = 3'd1,
    KP_CHECK      = 3'd2,
    KP_EXIT_DELAY = 3'd3,
    KP_LOCKOUT    = 3'd4
  } kp_state_e;

  // Security FSM states, consumed by the downstream arm/disarm target.
  localparam logic [2:0] SEC_DISARMED    = 3'd0;
  localparam logic [2:0] SEC_ARMED       = 3'd1;
  localparam logic [2:0] SEC_ENTRY_DELAY = 3'd2;
  localparam logic [2:0] SEC_ALARM       = 3'd3;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/alarm_cycle_timer.sv
// Saturating down-counter. Loads a cycle count, ticks down, never wraps.
// o_done is high in the cycle whose tick takes the count to zero (or when the
// count is already zero), so a load of N expires exactly N edges after the load.
module alarm_cycle_timer #(
  parameter int W = 8
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Count register: load has priority over tick; holds at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0) | (i_tick & (r_count == W'(1)));

endmodule

// File: rtl/alarm_keypad_ctrl.sv
// PIN-entry front end: collects keypad digits, checks them against PIN,
// arms after an exit delay or disarms at once, and locks out after repeated
// bad codes.
// Key handshake: a key transfers on a clock edge where key_valid & key_ready;
// key_valid/key_code must hold until then; key_ready depends only on state.
module alarm_keypad_ctrl
  import alarm_pkg::*;
#(
  parameter int                    PIN_DIGITS        = 4,
  parameter logic [4*PIN_DIGITS-1:0] PIN             = 16'h1234,
  parameter int                    TIMEOUT_CYCLES    = 1000,
  parameter int                    MAX_FAILS         = 3,
  parameter int                    LOCKOUT_CYCLES    = 5000,
  parameter int                    EXIT_DELAY_CYCLES = 100
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       arm,
  output logic       exit_pending,
  output logic       disarm_pulse,
  output logic       code_err,
  output logic       locked,
  output logic [2:0] dbg_state
);

  localparam int BW   = 4 * PIN_DIGITS;
  localparam int CW   = $clog2(PIN_DIGITS + 1);
  localparam int FW   = (MAX_FAILS > 1) ? $clog2(MAX_FAILS) : 1;
  localparam int TMAX = max3(TIMEOUT_CYCLES, LOCKOUT_CYCLES, EXIT_DELAY_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);

  kp_state_e     r_state, w_state_nxt;
  logic [BW-1:0] r_buf, w_buf_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic [FW-1:0] r_fails, w_fails_nxt;
  logic          r_arm, w_arm_nxt;
  logic          r_pend, w_pend_nxt;
  logic          r_disarm, w_disarm_nxt;
  logic          r_err, w_err_nxt;
  logic          r_locked, w_locked_nxt;

  logic          w_accept;
  logic          w_digit;
  logic          w_match;
  logic [BW-1:0] w_buf_shift;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic          w_tmr_tick;
  logic          w_tmr_done;

  assign key_ready = ~rst & ((r_state == KP_IDLE) | (r_state == KP_ENTRY) |
                             (r_state == KP_EXIT_DELAY));
  assign w_accept    = key_valid & key_ready;
  assign w_digit     = is_digit(key_code);
  assign w_buf_shift = (r_buf << 4) | BW'(key_code);
  assign w_match     = (r_cnt == CW'(PIN_DIGITS)) & ~r_ovf & (r_buf == PIN);
  assign w_tmr_tick  = (r_state == KP_ENTRY) | (r_state == KP_EXIT_DELAY) |
                       (r_state == KP_LOCKOUT);

  alarm_cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_tick     (w_tmr_tick),
    .o_done     (w_tmr_done)
  );

  // State and datapath registers; reset aborts everything, arm drops at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= KP_IDLE;
      r_buf    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_fails  <= '0;
      r_arm    <= 1'b0;
      r_pend   <= 1'b0;
      r_disarm <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_buf    <= w_buf_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ovf    <= w_ovf_nxt;
      r_fails  <= w_fails_nxt;
      r_arm    <= w_arm_nxt;
      r_pend   <= w_pend_nxt;
      r_disarm <= w_disarm_nxt;
      r_err    <= w_err_nxt;
      r_locked <= w_locked_nxt;
    end
  end

  // Next-state and next-output decode; an accepted key beats timer expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_cnt_nxt    = r_cnt;
    w_ovf_nxt    = r_ovf;
    w_fails_nxt  = r_fails;
    w_arm_nxt    = r_arm;
    w_pend_nxt   = r_pend;
    w_disarm_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    w_locked_nxt = r_locked;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    case (r_state)
      KP_IDLE: begin
        if (w_accept && w_digit) begin
          w_buf_nxt   = BW'(key_code);
          w_cnt_nxt   = CW'(1);
          w_ovf_nxt   = 1'b0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TW'(TIMEOUT_CYCLES);
          w_state_nxt = KP_ENTRY;
        end
      end
      KP_ENTRY: begin
        if (w_accept) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TW'(TIMEOUT_CYCLES);
          if (w_digit) begin
            w_buf_nxt = w_buf_shift;
            if (r_cnt == CW'(PIN_DIGITS)) w_ovf_nxt = 1'b1;
            else                          w_cnt_nxt = r_cnt + 1'b1;
          end else if (key_code == KEY_CLEAR) begin
            w_state_nxt = KP_IDLE;
          end else if (key_code == KEY_ENTER) begin
            w_state_nxt = KP_CHECK;
          end
        end else if (w_tmr_done) begin
          w_state_nxt = KP_IDLE;
        end
      end
      KP_CHECK: begin
        if (w_match && !r_arm) begin
          w_fails_nxt = '0;
          w_pend_nxt  = 1'b1;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TW'(EXIT_DELAY_CYCLES);
          w_state_nxt = KP_EXIT_DELAY;
        end else if (w_match) begin
          w_fails_nxt  = '0;
          w_arm_nxt    = 1'b0;
          w_disarm_nxt = 1'b1;
          w_state_nxt  = KP_IDLE;
        end else begin
          w_err_nxt = 1'b1;
          if ((int'(r_fails) + 1) == MAX_FAILS) begin
            w_fails_nxt  = '0;
            w_locked_nxt = 1'b1;
            w_tmr_load   = 1'b1;
            w_tmr_val    = TW'(LOCKOUT_CYCLES);
            w_state_nxt  = KP_LOCKOUT;
          end else begin
            w_fails_nxt = r_fails + 1'b1;
            w_state_nxt = KP_IDLE;
          end
        end
      end
      KP_EXIT_DELAY: begin
        if (w_accept && (key_code == KEY_CLEAR)) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = KP_IDLE;
        end else if (w_tmr_done) begin
          w_arm_nxt   = 1'b1;
          w_pend_nxt  = 1'b0;
          w_state_nxt = KP_IDLE;
        end
      end
      KP_LOCKOUT: begin
        if (w_tmr_done) begin
          w_locked_nxt = 1'b0;
          w_buf_nxt    = '0;
          w_cnt_nxt    = '0;
          w_ovf_nxt    = 1'b0;
          w_state_nxt  = KP_IDLE;
        end
      end
      default: w_state_nxt = KP_IDLE;
    endcase
  end

  assign arm          = r_arm;
  assign exit_pending = r_pend;
  assign disarm_pulse = r_disarm;
  assign code_err     = r_err;
  assign locked       = r_locked;
  assign dbg_state    = r_state;

endmodule
